// File: rtl/q2_sequencer_if.sv
// Q2 sequencer bus: opcode/front-panel inputs and datapath strobes.
// The master side is the sequencer; the slave side is the datapath/panel.
interface q2_sequencer_if;
    // Inputs to the sequencer
    logic [4:0] op;
    logic       dbus6;
    logic       f;
    logic       alu_cout;
    logic       mem_ready;
    logic       cont;
    logic       step_mode;
    logic       dep_sw;
    logic       incp_db;

    // Outputs from the sequencer
    logic [2:0] state;
    logic       rdp;
    logic       rdx;
    logic       rda;
    logic       rdm;
    logic       wro;
    logic       wra;
    logic       wrx;
    logic       wrp;
    logic       wrm;
    logic       wrf;
    logic       incp_clk;
    logic       xhin_shift;
    logic       xhin_p;
    logic       xhin_zero;
    logic       xhin_dbus;
    logic       xlin_shift;
    logic       xlin_dbus;
    logic       fout;
    logic       halt;

    modport master (
        input  op, dbus6, f, alu_cout, mem_ready, cont, step_mode, dep_sw, incp_db,
        output state, rdp, rdx, rda, rdm, wro, wra, wrx, wrp, wrm, wrf, incp_clk,
        output xhin_shift, xhin_p, xhin_zero, xhin_dbus, xlin_shift, xlin_dbus, fout, halt
    );

    modport slave (
        output op, dbus6, f, alu_cout, mem_ready, cont, step_mode, dep_sw, incp_db,
        input  state, rdp, rdx, rda, rdm, wro, wra, wrx, wrp, wrm, wrf, incp_clk,
        input  xhin_shift, xhin_p, xhin_zero, xhin_dbus, xlin_shift, xlin_dbus, fout, halt
    );
endinterface

// File: rtl/q2_sequencer.sv
// Q2 control unit: instruction state register, strobe decode, bit-serial ALU
// counter, memory-ready wait and halt/continue/single-step front panel.
// All strobes are combinational from the state register and current inputs.
module q2_sequencer #(
    parameter int unsigned WIDTH        = 12,
    parameter int unsigned CNT_W        = 4,
    parameter bit          RESET_HALTED = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    q2_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StLoad   = 3'd2,
        StDeref  = 3'd3,
        StExec   = 3'd4,
        StAlu    = 3'd5,
        StHalt   = 3'd6
    } state_e;

    localparam state_e           ResetState = RESET_HALTED ? StHalt : StFetch;
    // Loaded on ALU entry; the ALU state runs while counting down to zero inclusive.
    localparam logic [CNT_W-1:0] CntLoad    = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;

    // Local copies of the strobes, driven by the decode block below
    logic rdp, rda, rdm;
    logic wro, wra, wrx, wrp, wrm, wrf, incp_clk;
    logic xhin_shift, xhin_p, xhin_zero, xhin_dbus, xlin_shift, xlin_dbus;
    logic fout, halt;

    // Exec-state strobe terms, shared by decode and next-state logic
    logic exec_alu;
    logic exec_halt;
    logic jump_taken;
    logic store_op;

    assign exec_alu   = ~bus.op[4];
    assign exec_halt  = bus.op[4] & ~bus.op[3] & bus.op[2];
    assign jump_taken = bus.op[4] & bus.op[3] & ~(bus.op[2] & bus.f);
    assign store_op   = bus.op[4] & ~bus.op[3] & ~bus.op[2];

    // Instruction state register and serial ALU bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ResetState;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (bus.mem_ready) begin
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    // op is only valid here, one cycle after the wro edge
                    if (bus.op[1]) begin
                        state_q <= StLoad;
                    end else if (bus.op[0]) begin
                        state_q <= StDeref;
                    end else begin
                        state_q <= StExec;
                    end
                end
                StLoad: begin
                    if (bus.mem_ready) begin
                        if (bus.op[0]) begin
                            state_q <= StDeref;
                        end else begin
                            state_q <= StExec;
                        end
                    end
                end
                StDeref: begin
                    if (bus.mem_ready) begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (bus.mem_ready) begin
                        if (exec_alu) begin
                            state_q <= StAlu;
                            cnt_q   <= CntLoad;
                        end else if (exec_halt || bus.step_mode) begin
                            state_q <= StHalt;
                        end else begin
                            state_q <= StFetch;
                        end
                    end
                end
                StAlu: begin
                    // ALU cycles do not touch memory, so mem_ready is ignored
                    if (cnt_q == '0) begin
                        if (bus.step_mode) begin
                            state_q <= StHalt;
                        end else begin
                            state_q <= StFetch;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StHalt: begin
                    if (bus.cont) begin
                        state_q <= StFetch;
                    end
                end
                default: begin
                    // Unused encoding: park safely in HALT
                    state_q <= StHalt;
                end
            endcase
        end
    end

    // Datapath strobe decode from current state and inputs
    always_comb begin
        rdp        = 1'b0;
        rda        = 1'b0;
        rdm        = 1'b1;
        wro        = 1'b0;
        wra        = 1'b0;
        wrx        = 1'b0;
        wrp        = 1'b0;
        wrm        = 1'b0;
        wrf        = 1'b0;
        incp_clk   = 1'b0;
        xhin_shift = 1'b0;
        xhin_p     = 1'b0;
        xhin_zero  = 1'b0;
        xhin_dbus  = 1'b0;
        xlin_shift = 1'b0;
        xlin_dbus  = 1'b1;
        fout       = 1'b0;
        halt       = 1'b0;

        unique case (state_q)
            StFetch: begin
                rdp       = 1'b1;
                xhin_p    = ~bus.dbus6;
                xhin_zero = bus.dbus6;
                wro       = bus.mem_ready;
                incp_clk  = bus.mem_ready;
            end
            StDecode: begin
            end
            StLoad, StDeref: begin
                xhin_dbus = 1'b1;
                wrx       = bus.mem_ready;
            end
            StExec: begin
                rda  = 1'b1;
                rdm  = 1'b0;
                fout = ~bus.op[3];
                if (bus.mem_ready) begin
                    wrf = exec_alu;
                    wrp = jump_taken;
                    wrm = store_op;
                end
            end
            StAlu: begin
                xhin_shift = 1'b1;
                xlin_shift = 1'b1;
                xlin_dbus  = 1'b0;
                wra        = 1'b1;
                wrx        = 1'b1;
                wrf        = 1'b1;
                fout       = bus.alu_cout;
            end
            StHalt: begin
                halt     = 1'b1;
                wrm      = bus.dep_sw;
                incp_clk = bus.incp_db;
            end
            default: begin
            end
        endcase
    end

    assign bus.state      = state_q;
    assign bus.rdp        = rdp;
    assign bus.rdx        = ~rdp;
    assign bus.rda        = rda;
    assign bus.rdm        = rdm;
    assign bus.wro        = wro;
    assign bus.wra        = wra;
    assign bus.wrx        = wrx;
    assign bus.wrp        = wrp;
    assign bus.wrm        = wrm;
    assign bus.wrf        = wrf;
    assign bus.incp_clk   = incp_clk;
    assign bus.xhin_shift = xhin_shift;
    assign bus.xhin_p     = xhin_p;
    assign bus.xhin_zero  = xhin_zero;
    assign bus.xhin_dbus  = xhin_dbus;
    assign bus.xlin_shift = xlin_shift;
    assign bus.xlin_dbus  = xlin_dbus;
    assign bus.fout       = fout;
    assign bus.halt       = halt;

endmodule

// File: tb/tb_q2_sequencer.sv
// Scoreboard bench for q2_sequencer: each driven cycle pushes its expected
// state and masked strobe set; the negedge sampler pops and compares.
module tb_q2_sequencer;

    localparam logic [18:0] M_HALT = 19'd1 << 0;
    localparam logic [18:0] M_FOUT = 19'd1 << 1;
    localparam logic [18:0] M_XLD  = 19'd1 << 2;
    localparam logic [18:0] M_XLS  = 19'd1 << 3;
    localparam logic [18:0] M_XHD  = 19'd1 << 4;
    localparam logic [18:0] M_XHZ  = 19'd1 << 5;
    localparam logic [18:0] M_XHP  = 19'd1 << 6;
    localparam logic [18:0] M_XHS  = 19'd1 << 7;
    localparam logic [18:0] M_INCP = 19'd1 << 8;
    localparam logic [18:0] M_WRF  = 19'd1 << 9;
    localparam logic [18:0] M_WRM  = 19'd1 << 10;
    localparam logic [18:0] M_WRP  = 19'd1 << 11;
    localparam logic [18:0] M_WRX  = 19'd1 << 12;
    localparam logic [18:0] M_WRA  = 19'd1 << 13;
    localparam logic [18:0] M_WRO  = 19'd1 << 14;
    localparam logic [18:0] M_RDM  = 19'd1 << 15;
    localparam logic [18:0] M_RDA  = 19'd1 << 16;
    localparam logic [18:0] M_RDX  = 19'd1 << 17;
    localparam logic [18:0] M_RDP  = 19'd1 << 18;
    localparam logic [18:0] M_WRALL = M_WRO | M_WRA | M_WRX | M_WRP | M_WRM | M_WRF | M_INCP;

    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_LOAD = 3'd2, S_DEREF = 3'd3;
    localparam logic [2:0] S_EXEC = 3'd4, S_ALU = 3'd5, S_HALT = 3'd6;

    typedef struct packed {
        logic [2:0]  st;
        logic [18:0] mask;
        logic [18:0] val;
    } exp_t;

    logic clk;
    logic rst_n;
    int   num_checks;
    int   num_errors;

    exp_t        exp_q[$];
    string       tag_q[$];
    logic [18:0] obs;

    q2_sequencer_if bus();

    q2_sequencer #(
        .WIDTH        (12),
        .CNT_W        (4),
        .RESET_HALTED (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        obs = {bus.rdp, bus.rdx, bus.rda, bus.rdm, bus.wro, bus.wra, bus.wrx, bus.wrp,
               bus.wrm, bus.wrf, bus.incp_clk, bus.xhin_shift, bus.xhin_p, bus.xhin_zero,
               bus.xhin_dbus, bus.xlin_shift, bus.xlin_dbus, bus.fout, bus.halt};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        num_checks++;
        if (got !== want) begin
            num_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic ex(input string tag, input logic [2:0] st, input logic [18:0] mask,
                      input logic [18:0] val);
        exp_t e;
        e.st   = st;
        e.mask = mask;
        e.val  = val;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Compare this cycle's outputs at the negedge, then step past the next posedge
    task automatic tick();
        exp_t  e;
        string t;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check({t, ".state"}, 32'(bus.state), 32'(e.st));
            check({t, ".strobes"}, 32'(obs & e.mask), 32'(e.val & e.mask));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic [4:0] opv);
        bus.mem_ready = 1'b1;
        bus.dbus6     = 1'b0;
        ex("fetch", S_FETCH, M_WRALL | M_XHP | M_XHZ | M_RDP | M_RDX,
           M_WRO | M_INCP | M_XHP | M_RDP);
        tick();
        bus.op = opv;
        ex("decode", S_DECODE, M_WRALL | M_RDA | M_RDM, M_RDM);
        tick();
    endtask

    initial begin
        logic c;
        num_checks    = 0;
        num_errors    = 0;
        rst_n         = 1'b0;
        bus.op        = 5'b0;
        bus.dbus6     = 1'b0;
        bus.f         = 1'b0;
        bus.alu_cout  = 1'b0;
        bus.mem_ready = 1'b0;
        bus.cont      = 1'b0;
        bus.step_mode = 1'b0;
        bus.dep_sw    = 1'b0;
        bus.incp_db   = 1'b0;

        // Reset leaves the unit halted
        ex("reset", S_HALT, M_HALT | M_RDP | M_RDX | M_WRALL | M_XLD, M_HALT | M_RDX | M_XLD);
        tick();
        rst_n = 1'b1;

        // Front-panel deposit and PC increment pass through only in HALT
        bus.dep_sw  = 1'b1;
        bus.incp_db = 1'b1;
        ex("halt_panel", S_HALT, M_HALT | M_WRALL, M_HALT | M_WRM | M_INCP);
        tick();
        bus.dep_sw  = 1'b0;
        bus.incp_db = 1'b0;
        bus.cont    = 1'b1;
        ex("halt_cont", S_HALT, M_HALT | M_WRALL, M_HALT);
        tick();
        bus.cont = 1'b0;

        // Fetch waits on mem_ready; zero-page select follows dbus6
        bus.dbus6 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ex("fetch_wait", S_FETCH, M_HALT | M_RDP | M_RDX | M_WRALL | M_XHZ | M_XHP,
               M_RDP | M_XHZ);
            tick();
        end
        bus.mem_ready = 1'b1;
        ex("fetch_go", S_FETCH, M_WRALL | M_XHZ | M_XHP, M_WRO | M_INCP | M_XHZ);
        tick();

        // Load + deref, then ALU op
        bus.op = 5'b00011;
        ex("decode_ld", S_DECODE, M_WRALL | M_RDM | M_RDA, M_RDM);
        tick();
        ex("load", S_LOAD, M_WRALL | M_XHD, M_WRX | M_XHD);
        tick();
        ex("deref", S_DEREF, M_WRALL | M_XHD, M_WRX | M_XHD);
        tick();
        ex("exec_alu", S_EXEC, M_WRALL | M_RDA | M_RDM | M_FOUT, M_RDA | M_WRF | M_FOUT);
        tick();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            c = 1'($urandom_range(0, 1));
            bus.alu_cout = c;
            ex("alu", S_ALU, M_WRALL | M_XHS | M_XLS | M_XLD | M_FOUT | M_XHD,
               M_WRA | M_WRX | M_WRF | M_XHS | M_XLS | (c ? M_FOUT : 19'd0));
            tick();
        end
        bus.alu_cout = 1'b0;

        // Conditional jump: not taken with f=1, then taken with f=0
        fetch_decode(5'b11100);
        bus.f         = 1'b1;
        bus.mem_ready = 1'b0;
        ex("jmp_wait", S_EXEC, M_WRALL | M_FOUT, 19'd0);
        tick();
        bus.mem_ready = 1'b1;
        ex("jmp_f1", S_EXEC, M_WRALL | M_FOUT, 19'd0);
        tick();
        fetch_decode(5'b11100);
        bus.f = 1'b0;
        ex("jmp_f0", S_EXEC, M_WRALL | M_FOUT, M_WRP);
        tick();

        // Halt instruction
        fetch_decode(5'b10100);
        ex("exec_hlt", S_EXEC, M_WRALL | M_FOUT, M_FOUT);
        tick();
        bus.mem_ready = 1'b0;
        ex("halted", S_HALT, M_HALT | M_WRALL | M_RDP, M_HALT);
        tick();

        // Single-step a store
        bus.step_mode = 1'b1;
        bus.cont      = 1'b1;
        ex("step_cont", S_HALT, M_HALT, M_HALT);
        tick();
        bus.cont = 1'b0;
        fetch_decode(5'b10000);
        ex("exec_st", S_EXEC, M_WRALL | M_FOUT, M_WRM | M_FOUT);
        tick();
        bus.mem_ready = 1'b0;
        bus.dep_sw    = 1'b1;
        ex("step_halt", S_HALT, M_HALT | M_WRALL, M_HALT | M_WRM);
        tick();
        bus.dep_sw    = 1'b0;
        bus.step_mode = 1'b0;

        // Reset in the middle of an ALU sequence
        bus.cont = 1'b1;
        ex("cont2", S_HALT, M_HALT, M_HALT);
        tick();
        bus.cont = 1'b0;
        fetch_decode(5'b00000);
        ex("exec_alu2", S_EXEC, M_WRALL, M_WRF);
        tick();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ex("alu2", S_ALU, M_WRALL, M_WRA | M_WRX | M_WRF);
            tick();
        end
        rst_n = 1'b0;
        ex("rst_alu", S_HALT, M_HALT | M_WRALL | M_XLD, M_HALT | M_XLD);
        tick();
        rst_n = 1'b1;
        ex("post_rst", S_HALT, M_HALT | M_WRALL, M_HALT);
        tick();
        bus.cont = 1'b1;
        ex("post_cont", S_HALT, M_HALT | M_WRALL, M_HALT);
        tick();
        bus.cont = 1'b0;
        ex("post_fetch", S_FETCH, M_HALT | M_WRALL | M_RDP, M_RDP);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
